// File: rtl/mq_shift_pkg.sv
// Shared types and constants for the multiplier/divider Q shift register.
// Encodings line up with the 2-bit mode and 1-bit dir port values.
package mq_shift_pkg;

    typedef enum logic [1:0] {
        LOGIC  = 2'b00,
        ARITH  = 2'b01,
        ROTATE = 2'b10
    } shift_mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // The reserved encoding 2'b11 behaves as LOGIC.
    function automatic shift_mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return ARITH;
            2'b10:   return ROTATE;
            default: return LOGIC;
        endcase
    endfunction

endpackage

// File: rtl/mq_shift_step.sv
// One combinational shift step: next register value plus the bit shifted out.
// Shared by the single-step and counted-shift paths of mq_shift_register.
module mq_shift_step
    import mq_shift_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] d,
    input  logic         dir,
    input  shift_mode_t  mode,
    input  logic         ser_in,
    output logic [W-1:0] d_next,
    output logic         bit_out
);

    logic fill;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        fill    = ser_in;
        d_next  = d;
        bit_out = 1'b0;
        if (dir == DIR_RIGHT) begin
            case (mode)
                ARITH:   fill = d[W-1];
                ROTATE:  fill = d[0];
                default: fill = ser_in;
            endcase
            d_next  = {fill, d[W-1:1]};
            bit_out = d[0];
        end else begin
            case (mode)
                ARITH:   fill = 1'b0;
                ROTATE:  fill = d[W-1];
                default: fill = ser_in;
            endcase
            d_next  = {d[W-2:0], fill};
            bit_out = d[W-1];
        end
    end

endmodule

// File: rtl/mq_shift_register.sv
// Parametrised Q shift register: parallel load, single-step shift, and a
// counted multi-step shift under a start/busy/done handshake.
module mq_shift_register
    import mq_shift_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  data_in,
    input  logic          shift,
    input  logic          dir,
    input  logic [1:0]    mode,
    input  logic          ser_in,
    input  logic          start,
    input  logic [CW-1:0] count,
    output logic [W-1:0]  data_out,
    output logic          ser_out,
    output logic          busy,
    output logic          done
);

    localparam logic [CW-1:0] W_CNT = CW'(W);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          dir_q;
    shift_mode_t   mode_q;

    logic          step_dir;
    shift_mode_t   step_mode;
    logic [W-1:0]  step_d;
    logic          step_bit;
    logic [CW-1:0] count_clamped;

    // Counted steps use controls captured at start; single steps use the live ones.
    assign step_dir      = (state == RUN) ? dir_q  : dir;
    assign step_mode     = (state == RUN) ? mode_q : decode_mode(mode);
    assign count_clamped = (count > W_CNT) ? W_CNT : count;

    mq_shift_step #(.W(W)) u_step (
        .d       (data_out),
        .dir     (step_dir),
        .mode    (step_mode),
        .ser_in  (ser_in),
        .d_next  (step_d),
        .bit_out (step_bit)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dir_q    <= DIR_RIGHT;
            mode_q   <= LOGIC;
            data_out <= '0;
            ser_out  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            cnt    <= count_clamped;
                            dir_q  <= dir;
                            mode_q <= decode_mode(mode);
                            state  <= RUN;
                            busy   <= 1'b1;
                        end
                    end else if (shift) begin
                        data_out <= step_d;
                        ser_out  <= step_bit;
                    end else if (load) begin
                        data_out <= data_in;
                    end
                end
                RUN: begin
                    data_out <= step_d;
                    ser_out  <= step_bit;
                    cnt      <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mq_shift_register.sv
// Self-checking bench for mq_shift_register: directed scenarios plus random
// traffic, compared every cycle against an arithmetic reference model.
module tb_mq_shift_register;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [W-1:0]  data_in;
    logic          shift;
    logic          dir;
    logic [1:0]    mode;
    logic          ser_in;
    logic          start;
    logic [CW-1:0] count;
    logic [W-1:0]  data_out;
    logic          ser_out;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    // Reference model state: register contents, last shifted bit, steps still owed.
    int unsigned m_data;
    int unsigned m_ser;
    int          m_left;
    int unsigned m_done;
    logic        m_dir;
    logic [1:0]  m_mode;

    mq_shift_register #(.W(W), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .data_in  (data_in),
        .shift    (shift),
        .dir      (dir),
        .mode     (mode),
        .ser_in   (ser_in),
        .start    (start),
        .count    (count),
        .data_out (data_out),
        .ser_out  (ser_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Step computed with plain integer arithmetic on the value.
    function automatic int unsigned ref_step(input int unsigned v, input logic d_left,
                                             input logic [1:0] m, input logic s,
                                             output int unsigned so);
        int unsigned top = 1 << (W - 1);
        int unsigned msb = (v / top) % 2;
        int unsigned lsb = v % 2;
        int unsigned fill;
        if (!d_left) begin
            so = lsb;
            case (m)
                2'b01:   fill = msb;
                2'b10:   fill = lsb;
                default: fill = s;
            endcase
            return v / 2 + fill * top;
        end
        so = msb;
        case (m)
            2'b01:   fill = 0;
            2'b10:   fill = msb;
            default: fill = s;
        endcase
        return (v * 2) % (1 << W) + fill;
    endfunction

    task automatic model_edge();
        int unsigned so;
        int          n;
        if (rst) begin
            m_data = 0; m_ser = 0; m_left = 0; m_done = 0;
            return;
        end
        m_done = 0;
        if (m_left > 0) begin
            m_data = ref_step(m_data, m_dir, m_mode, ser_in, so);
            m_ser  = so;
            m_left--;
            if (m_left == 0) m_done = 1;
        end else if (start) begin
            n = (int'(count) > W) ? W : int'(count);
            if (n == 0) m_done = 1;
            else begin
                m_left = n; m_dir = dir; m_mode = mode;
            end
        end else if (shift) begin
            m_data = ref_step(m_data, dir, mode, ser_in, so);
            m_ser  = so;
        end else if (load) begin
            m_data = data_in;
        end
    endtask

    task automatic compare_all();
        check("data_out", 32'(data_out), m_data);
        check("ser_out",  32'(ser_out),  m_ser);
        check("busy",     32'(busy),     32'(m_left > 0));
        check("done",     32'(done),     m_done);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        load = 0; shift = 0; start = 0; count = '0;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        idle_inputs(); load = 1; data_in = v;
        tick();
        load = 0;
    endtask

    task automatic do_start(input int n, input logic d, input logic [1:0] m);
        idle_inputs(); start = 1; count = CW'(n); dir = d; mode = m;
        tick();
        start = 0; count = '0;
    endtask

    initial begin
        rst = 1; idle_inputs(); data_in = '0; dir = 0; mode = 2'b00; ser_in = 0;
        m_data = 0; m_ser = 0; m_left = 0; m_done = 0; m_dir = 0; m_mode = 0;
        #1;
        compare_all();
        tick();
        rst = 0;

        // Single logic right step with ser_in=1.
        do_load(8'h0A);
        idle_inputs(); shift = 1; dir = 0; mode = 2'b00; ser_in = 1;
        tick();
        shift = 0;
        check("single_step_data", 32'(data_out), 32'h85);

        // Arithmetic right by 3.
        do_load(8'h90);
        do_start(3, 1'b0, 2'b01);
        repeat (3) begin
            check("arith_busy", 32'(busy), 32'd1);
            tick();
        end
        check("arith_data", 32'(data_out), 32'hF2);
        check("arith_done", 32'(done), 32'd1);
        tick();
        check("arith_done_low", 32'(done), 32'd0);

        // Logic left by 4 with ser_in=0.
        ser_in = 0;
        do_load(8'h81);
        do_start(4, 1'b1, 2'b00);
        repeat (4) tick();
        check("left_data", 32'(data_out), 32'h10);
        check("left_ser_out", 32'(ser_out), 32'd0);

        // Rotate right by 12 clamps to 8, giving back the original value.
        do_load(8'h81);
        do_start(12, 1'b0, 2'b10);
        repeat (8) begin
            check("clamp_busy", 32'(busy), 32'd1);
            tick();
        end
        check("clamp_data", 32'(data_out), 32'h81);
        check("clamp_busy_end", 32'(busy), 32'd0);

        // Zero count: immediate done, never busy.
        do_start(0, 1'b0, 2'b00);
        check("zero_done", 32'(done), 32'd1);
        check("zero_data", 32'(data_out), 32'h81);
        tick();

        // Load during a counted shift is ignored.
        do_load(8'h55);
        do_start(5, 1'b0, 2'b10);
        tick();
        load = 1; data_in = 8'hFF;
        tick();
        load = 0;
        repeat (3) tick();
        check("ignore_load_data", 32'(data_out), 32'hAA);
        check("ignore_load_done", 32'(done), 32'd1);

        // Async reset mid-operation aborts without a done pulse.
        do_load(8'h55);
        do_start(5, 1'b0, 2'b10);
        repeat (2) tick();
        rst = 1;
        #1;
        check("abort_data", 32'(data_out), 32'h0);
        check("abort_busy", 32'(busy), 32'd0);
        m_data = 0; m_ser = 0; m_left = 0; m_done = 0;
        tick();
        rst = 0;
        repeat (6) begin
            tick();
            check("abort_no_done", 32'(done), 32'd0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            load    = ($urandom_range(0, 3) == 0);
            shift   = ($urandom_range(0, 3) == 0);
            start   = ($urandom_range(0, 7) == 0);
            count   = CW'($urandom_range(0, 13));
            dir     = 1'($urandom);
            mode    = 2'($urandom);
            ser_in  = 1'($urandom);
            data_in = W'($urandom);
            tick();
        end
        rst = 0; idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
